// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: single-outstanding req/ack data-bus access
// with core stall, read-word capture and access timeout.
module lsu_bus_ctrl #(
  parameter int REG_LEN = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [31:0]        addr,
  input  logic [REG_LEN-1:0] wdata,
  input  logic [3:0]         be,
  output logic               stall,
  output logic [REG_LEN-1:0] rdata,
  output logic               err,
  output logic               bus_req,
  output logic               bus_we,
  output logic [31:0]        bus_addr,
  output logic [3:0]         bus_be,
  output logic [REG_LEN-1:0] bus_wdata,
  input  logic               bus_ack,
  input  logic [REG_LEN-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t             state, state_d;
  logic [7:0]         cnt, cnt_d;
  logic               we_d, err_d;
  logic [31:0]        addr_d;
  logic [3:0]         be_d;
  logic [REG_LEN-1:0] wdata_d, rdata_d;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_be    <= be_d;
      bus_wdata <= wdata_d;
      rdata     <= rdata_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = bus_we;
    addr_d  = bus_addr;
    be_d    = bus_be;
    wdata_d = bus_wdata;
    rdata_d = rdata;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_wr || mem_rd) begin
          we_d    = mem_wr;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = mem_wr ? be : 4'b1111;
          wdata_d = wdata;
          cnt_d   = '0;
          // An all-zero byte-enable store has nothing to put on the bus.
          state_d = (mem_wr && be == 4'b0000) ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_ack) begin
          if (!bus_we) rdata_d = bus_rdata;
          state_d = DONE;
        end else if (cnt == CNT_LAST) begin
          if (!bus_we) rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_req = (state == REQ);
  assign stall   = (mem_rd | mem_wr) & (state != DONE);

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Randomized bench for lsu_bus_ctrl against a transaction-level model
// of expected per-cycle bus/stall behaviour.
module tb_lsu_bus_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        stall, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(
    .REG_LEN(32),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .stall    (stall),
    .rdata    (rdata),
    .err      (err),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_be   (bus_be),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h exp %h", tag, $time, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk();
    chk("idle_stall", 32'(stall), 0);
    chk("idle_req", 32'(bus_req), 0);
    chk("idle_err", 32'(err), 0);
    chk("idle_rdata", rdata, m_rdata);
  endtask

  // Starts in cycle 0 of an access, returns in its DONE cycle.
  // w = wait cycles before ack; w >= TO means the slave never acks.
  task automatic xact(input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input int w,
                      input logic [31:0] rdv);
    bit is_wr, to;
    int n;
    mem_rd    = rd;
    mem_wr    = wr;
    addr      = a;
    wdata     = d;
    be        = b;
    bus_ack   = 1'($urandom);
    bus_rdata = $urandom;
    #1;
    chk("c0_stall", 32'(stall), 1);
    chk("c0_req", 32'(bus_req), 0);
    is_wr = wr;
    if (wr && b == 4'b0000) begin
      next();
      bus_ack = 1'($urandom);
      #1;
      chk("be0_stall", 32'(stall), 0);
      chk("be0_req", 32'(bus_req), 0);
      chk("be0_err", 32'(err), 0);
      chk("be0_rdata", rdata, m_rdata);
      return;
    end
    to = (w >= TO);
    n  = to ? TO : w + 1;
    for (int k = 1; k <= n; k++) begin
      next();
      bus_ack   = (!to && k == w + 1);
      bus_rdata = bus_ack ? rdv : $urandom;
      #1;
      chk("req_req", 32'(bus_req), 1);
      chk("req_stall", 32'(stall), 1);
      chk("req_addr", bus_addr, {a[31:2], 2'b00});
      chk("req_we", 32'(bus_we), 32'(is_wr));
      chk("req_be", 32'(bus_be), is_wr ? 32'(b) : 32'hf);
      if (is_wr) chk("req_wdata", bus_wdata, d);
    end
    if (!is_wr) m_rdata = to ? 32'h0 : rdv;
    next();
    bus_ack   = 1'($urandom);
    bus_rdata = $urandom;
    #1;
    chk("done_stall", 32'(stall), 0);
    chk("done_req", 32'(bus_req), 0);
    chk("done_err", 32'(err), 32'(to));
    chk("done_rdata", rdata, m_rdata);
  endtask

  task automatic drop();
    mem_rd  = 0;
    mem_wr  = 0;
    bus_ack = 1'($urandom);
  endtask

  initial begin
    int op, w, gap;
    logic [3:0] b;
    rst = 1; mem_rd = 0; mem_wr = 0; addr = 0; wdata = 0; be = 0;
    bus_ack = 0; bus_rdata = 0; m_rdata = 0;
    next(); next();
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", 32'(bus_be), 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(err), 0);
    rst = 0;
    next();

    // Directed: test-plan scenarios.
    xact(0, 1, 32'h103, 32'h12345678, 4'b1111, 0, 0);
    next(); drop(); #1; idle_chk();
    next();
    xact(0, 1, 32'h0, 32'h78000000, 4'b1000, 3, 0);
    next(); drop(); #1; idle_chk();
    next();
    xact(1, 0, 32'h200, 32'h0, 4'b0000, 1, 32'hDEADBEEF);
    next(); drop(); #1; idle_chk();
    next(); drop(); #1; idle_chk();
    next();
    xact(1, 0, 32'h204, 32'h0, 4'b1111, TO + 4, 32'h0);
    next(); drop(); #1; idle_chk();
    next();
    xact(1, 1, 32'h305, 32'hCAFEF00D, 4'b0011, 0, 32'h1);
    next(); drop(); #1; idle_chk();
    next();
    xact(0, 1, 32'h400, 32'h55, 4'b0000, 0, 0);
    next(); drop(); bus_ack = 1; #1; idle_chk();
    next(); bus_ack = 1; #1; idle_chk();
    next();
    xact(1, 0, 32'h500, 0, 0, TO - 1, 32'hA5A5A5A5);
    next(); drop(); #1; idle_chk();

    // Reset in the second wait cycle of a read.
    next();
    mem_rd = 1; addr = 32'h600; bus_ack = 0;
    next(); next();
    chk("mid_req", 32'(bus_req), 1);
    rst = 1;
    next();
    m_rdata = 0;
    chk("mid_rst_req", 32'(bus_req), 0);
    chk("mid_rst_rdata", rdata, 0);
    rst = 0; mem_rd = 0; bus_ack = 1; bus_rdata = 32'h77;
    next(); #1; idle_chk();
    next();
    xact(1, 0, 32'h604, 0, 0, 0, 32'h13572468);
    next(); drop(); #1; idle_chk();
    next();

    // Randomized accesses with random waits and back-to-back gaps.
    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 3);
      b  = 4'($urandom);
      if (op == 3 && ($urandom_range(0, 3) == 0)) b = 4'b0000;
      case ($urandom_range(0, 9))
        0:       w = TO - 1;
        1:       w = TO;
        2:       w = TO + $urandom_range(1, 5);
        default: w = $urandom_range(0, 4);
      endcase
      xact(op == 0 || op == 3, op != 0, $urandom, $urandom, b, w, $urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        next(); drop(); #1; idle_chk();
      end
      next();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
